// File: rtl/mem_l9_pair_ctrl.sv
// mem_l9_pair_ctrl
// Fill/drain controller for the layer-9 dual-port feature-map BRAM.
// Upstream words are packed in pairs and written on both ports with one
// shared strobe. On rd_start the frame is read back as (even, odd) word pairs.
// The BRAM has a 1-cycle registered read, so each drained pair takes an
// address cycle, a wait cycle and an output cycle.
module mem_l9_pair_ctrl #(
    parameter int DATA_WIDTH      = 16,
    parameter int BRAM_addr_WIDTH = 10,
    parameter int N_WORDS         = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       rd_start,
    input  logic                       new_frame,
    output logic [DATA_WIDTH-1:0]      m_data1,
    output logic [DATA_WIDTH-1:0]      m_data2,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       done_wr,
    output logic                       done_rd,
    output logic [BRAM_addr_WIDTH-1:0] BRAM1_addr1,
    output logic [BRAM_addr_WIDTH-1:0] BRAM1_addr2,
    output logic [DATA_WIDTH-1:0]      BRAM1_in1,
    output logic [DATA_WIDTH-1:0]      BRAM1_in2,
    output logic                       wr,
    input  logic [DATA_WIDTH-1:0]      BRAM1_out1,
    input  logic [DATA_WIDTH-1:0]      BRAM1_out2
);

    // Pointers carry one extra bit so a full 2**AW frame does not wrap to 0.
    localparam int AW = BRAM_addr_WIDTH;
    localparam int PW = BRAM_addr_WIDTH + 1;
    localparam logic [PW-1:0] LAST_P = PW'(N_WORDS);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_FULL    = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic                    hold_vld_r;

    logic                    accept_s;
    logic                    pair_ok_s;
    logic                    handshake_s;
    logic [PW-1:0]           wr_ptr_inc_s;
    logic [PW-1:0]           rd_ptr_inc_s;
    logic                    wr_last_s;
    logic                    rd_last_s;

    // s_ready is combinational so a word can be taken every cycle while filling.
    assign s_ready      = (state_r == S_FILL) && !rst;
    assign accept_s     = s_valid && s_ready;
    assign pair_ok_s    = accept_s && hold_vld_r;
    assign handshake_s  = m_valid && m_ready;
    assign wr_ptr_inc_s = wr_ptr_r + PW'(2);
    assign rd_ptr_inc_s = rd_ptr_r + PW'(2);
    assign wr_last_s    = (wr_ptr_inc_s == LAST_P);
    assign rd_last_s    = (rd_ptr_inc_s == LAST_P);

    // State register with synchronous reset back to filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FILL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; new_frame has priority over rd_start in S_DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_FILL: begin
                if (pair_ok_s && wr_last_s) begin
                    state_next_s = S_FULL;
                end else begin
                    state_next_s = S_FILL;
                end
            end
            S_FULL: begin
                if (rd_start) begin
                    state_next_s = S_RD_ADDR;
                end else begin
                    state_next_s = S_FULL;
                end
            end
            S_RD_ADDR: state_next_s = S_RD_WAIT;
            S_RD_WAIT: state_next_s = S_RD_OUT;
            S_RD_OUT: begin
                if (handshake_s) begin
                    if (rd_last_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_RD_ADDR;
                    end
                end else begin
                    state_next_s = S_RD_OUT;
                end
            end
            S_DONE: begin
                if (new_frame) begin
                    state_next_s = S_FILL;
                end else if (rd_start) begin
                    state_next_s = S_RD_ADDR;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_FILL;
        endcase
    end

    // Datapath: pair packing, BRAM port registers, read capture and status flags.
    // Read addresses are loaded on the edge that enters S_RD_ADDR so the BRAM
    // samples them at the S_RD_ADDR -> S_RD_WAIT edge and the data is ready
    // to capture at the S_RD_WAIT -> S_RD_OUT edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            hold_r      <= {DATA_WIDTH{1'b0}};
            hold_vld_r  <= 1'b0;
            wr          <= 1'b0;
            BRAM1_addr1 <= {AW{1'b0}};
            BRAM1_addr2 <= {AW{1'b0}};
            BRAM1_in1   <= {DATA_WIDTH{1'b0}};
            BRAM1_in2   <= {DATA_WIDTH{1'b0}};
            m_data1     <= {DATA_WIDTH{1'b0}};
            m_data2     <= {DATA_WIDTH{1'b0}};
            m_valid     <= 1'b0;
            done_wr     <= 1'b0;
            done_rd     <= 1'b0;
        end else begin
            wr <= 1'b0;
            case (state_r)
                S_FILL: begin
                    if (accept_s) begin
                        if (hold_vld_r) begin
                            wr          <= 1'b1;
                            BRAM1_addr1 <= wr_ptr_r[AW-1:0];
                            BRAM1_addr2 <= wr_ptr_r[AW-1:0] + AW'(1);
                            BRAM1_in1   <= hold_r;
                            BRAM1_in2   <= s_data;
                            wr_ptr_r    <= wr_ptr_inc_s;
                            hold_vld_r  <= 1'b0;
                            if (wr_last_s) begin
                                done_wr <= 1'b1;
                            end
                        end else begin
                            hold_r     <= s_data;
                            hold_vld_r <= 1'b1;
                        end
                    end
                end
                S_FULL: begin
                    if (rd_start) begin
                        rd_ptr_r    <= {PW{1'b0}};
                        BRAM1_addr1 <= {AW{1'b0}};
                        BRAM1_addr2 <= AW'(1);
                    end
                end
                S_RD_ADDR: begin
                    m_valid <= 1'b0;
                end
                S_RD_WAIT: begin
                    m_data1 <= BRAM1_out1;
                    m_data2 <= BRAM1_out2;
                    m_valid <= 1'b1;
                end
                S_RD_OUT: begin
                    if (handshake_s) begin
                        m_valid  <= 1'b0;
                        rd_ptr_r <= rd_ptr_inc_s;
                        if (rd_last_s) begin
                            done_rd <= 1'b1;
                        end else begin
                            BRAM1_addr1 <= rd_ptr_inc_s[AW-1:0];
                            BRAM1_addr2 <= rd_ptr_inc_s[AW-1:0] + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (new_frame) begin
                        wr_ptr_r   <= {PW{1'b0}};
                        hold_vld_r <= 1'b0;
                        done_wr    <= 1'b0;
                        done_rd    <= 1'b0;
                    end else if (rd_start) begin
                        rd_ptr_r    <= {PW{1'b0}};
                        done_rd     <= 1'b0;
                        BRAM1_addr1 <= {AW{1'b0}};
                        BRAM1_addr2 <= AW'(1);
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_l9_pair_ctrl.sv
// Self-checking bench for mem_l9_pair_ctrl (DW=16, AW=4, N_WORDS=8).
// A small BRAM model sits beside the DUT; writes and drained pairs are logged
// each cycle and compared against a frame model: pair k of a frame is
// (addr 2k, addr 2k+1, word 2k, word 2k+1).
module tb_mem_l9_pair_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          rd_start;
    logic          new_frame;
    logic [DW-1:0] m_data1;
    logic [DW-1:0] m_data2;
    logic          m_valid;
    logic          m_ready;
    logic          done_wr;
    logic          done_rd;
    logic [AW-1:0] BRAM1_addr1;
    logic [AW-1:0] BRAM1_addr2;
    logic [DW-1:0] BRAM1_in1;
    logic [DW-1:0] BRAM1_in2;
    logic          wr;
    logic [DW-1:0] BRAM1_out1;
    logic [DW-1:0] BRAM1_out2;

    mem_l9_pair_ctrl #(
        .DATA_WIDTH(DW),
        .BRAM_addr_WIDTH(AW),
        .N_WORDS(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rd_start(rd_start), .new_frame(new_frame),
        .m_data1(m_data1), .m_data2(m_data2), .m_valid(m_valid), .m_ready(m_ready),
        .done_wr(done_wr), .done_rd(done_rd),
        .BRAM1_addr1(BRAM1_addr1), .BRAM1_addr2(BRAM1_addr2),
        .BRAM1_in1(BRAM1_in1), .BRAM1_in2(BRAM1_in2), .wr(wr),
        .BRAM1_out1(BRAM1_out1), .BRAM1_out2(BRAM1_out2)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM with shared write strobe and registered read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (wr) begin
            mem[BRAM1_addr1] <= BRAM1_in1;
            mem[BRAM1_addr2] <= BRAM1_in2;
        end
        BRAM1_out1 <= mem[BRAM1_addr1];
        BRAM1_out2 <= mem[BRAM1_addr2];
    end

    typedef struct packed {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          done;
    } wr_rec_t;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [31:0]   c;
    } rd_rec_t;

    typedef struct {
        logic [DW-1:0] w_even;
        logic [DW-1:0] w_odd;
        logic [AW-1:0] exp_a1;
        logic [AW-1:0] exp_a2;
        logic          exp_done;
    } vec_t;

    wr_rec_t       wr_q [$];
    rd_rec_t       rd_q [$];
    vec_t          tab  [4];
    logic [DW-1:0] cur_w [NW];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc_cnt     = 0;
    bit            acc_s;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: log DUT activity at the falling edge, return 1 time unit after the rising edge.
    task automatic cycle();
        wr_rec_t w;
        rd_rec_t r;
        @(negedge clk);
        if (wr) begin
            w = '{a1: BRAM1_addr1, a2: BRAM1_addr2, d1: BRAM1_in1, d2: BRAM1_in2, done: done_wr};
            wr_q.push_back(w);
        end
        if (m_valid && m_ready) begin
            r = '{d1: m_data1, d2: m_data2, c: 32'(cyc_cnt)};
            rd_q.push_back(r);
        end
        acc_s = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    // Stream cur_w: mode 0 back-to-back, 1 one word per 3 cycles, 2 random valid.
    task automatic fill(input int mode, input bit poke_rd);
        int idx   = 0;
        int guard = 0;
        s_data  = cur_w[0];
        s_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (idx < NW && guard < 400) begin
            cycle();
            guard++;
            if (acc_s) begin
                idx++;
                if (idx < NW) begin
                    s_data = cur_w[idx];
                    if (mode == 1) begin
                        s_valid  = 1'b0;
                        rd_start = poke_rd;
                        cycle();
                        rd_start = 1'b0;
                        cycle();
                        s_valid = 1'b1;
                    end
                end
            end
            if (idx >= NW) begin
                s_valid = 1'b0;
            end else if (mode == 2) begin
                s_valid = 1'($urandom_range(0, 1));
            end
        end
        s_valid  = 1'b0;
        rd_start = 1'b0;
        chk("fill_words_accepted", 128'(idx), 128'(NW));
        cycle();
    endtask

    // Pulse rd_start and collect four pairs; mode 0 m_ready=1, mode 1 random m_ready.
    task automatic drain(input int mode);
        int base  = rd_q.size();
        int guard = 0;
        m_ready  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        while (rd_q.size() - base < NW / 2 && guard < 400) begin
            if (mode == 1) begin
                m_ready = 1'($urandom_range(0, 1));
            end
            cycle();
            guard++;
        end
        m_ready = 1'b0;
        chk("drain_pair_count", 128'(rd_q.size() - base), 128'(NW / 2));
    endtask

    // Frame model for writes: pair k lands at (2k, 2k+1); only the last raises done_wr.
    task automatic check_writes(input int base, input string tag);
        wr_rec_t e;
        chk({tag, "_wr_count"}, 128'(wr_q.size() - base), 128'(NW / 2));
        for (int k = 0; k < NW / 2; k++) begin
            e = '{a1: AW'(2 * k), a2: AW'(2 * k + 1), d1: cur_w[2 * k], d2: cur_w[2 * k + 1],
                  done: (k == NW / 2 - 1)};
            if (base + k < wr_q.size()) begin
                chk({tag, "_wr_rec"}, 128'(wr_q[base + k]), 128'(e));
            end
        end
    endtask

    // Frame model for reads: pairs come back in address order.
    task automatic check_reads(input int base, input string tag);
        for (int k = 0; k < NW / 2; k++) begin
            if (base + k < rd_q.size()) begin
                chk({tag, "_rd_pair"}, {rd_q[base + k].d1, rd_q[base + k].d2},
                    {cur_w[2 * k], cur_w[2 * k + 1]});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rb;
        int            wb;
        int            stall;
        int            guard;
        logic [DW-1:0] snap1;
        logic [DW-1:0] snap2;

        tab[0] = '{16'h0011, 16'h0022, 4'd0, 4'd1, 1'b0};
        tab[1] = '{16'h0033, 16'h0044, 4'd2, 4'd3, 1'b0};
        tab[2] = '{16'h0055, 16'h0066, 4'd4, 4'd5, 1'b0};
        tab[3] = '{16'h0077, 16'h0088, 4'd6, 4'd7, 1'b1};

        rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000;
        rd_start = 1'b0; new_frame = 1'b0; m_ready = 1'b0;

        // 1: reset values and s_ready gating
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {m_data1, m_data2, m_valid, done_wr, done_rd, BRAM1_addr1,
                              BRAM1_addr2, BRAM1_in1, BRAM1_in2, wr, s_ready}, 128'd0);
        rst = 1'b0;
        #1;
        chk("s_ready_after_reset", 128'(s_ready), 128'd1);

        // 2: back-to-back fill, compared against the vector table
        for (int k = 0; k < 4; k++) begin
            cur_w[2 * k]     = tab[k].w_even;
            cur_w[2 * k + 1] = tab[k].w_odd;
        end
        wb = wr_q.size();
        fill(0, 1'b0);
        chk("s2_wr_count", 128'(wr_q.size() - wb), 128'd4);
        for (int k = 0; k < 4; k++) begin
            if (wb + k < wr_q.size()) begin
                chk("s2_wr_vector", 128'(wr_q[wb + k]),
                    {tab[k].exp_a1, tab[k].exp_a2, tab[k].w_even, tab[k].w_odd, tab[k].exp_done});
            end
        end
        chk("s2_s_ready_full", 128'(s_ready), 128'd0);
        chk("s2_done_wr", 128'(done_wr), 128'd1);

        // 3: drain with m_ready=1, one pair every 3 cycles
        rb = rd_q.size();
        wb = wr_q.size();
        drain(0);
        for (int k = 0; k < 4; k++) begin
            if (rb + k < rd_q.size()) begin
                chk("s3_rd_vector", {rd_q[rb + k].d1, rd_q[rb + k].d2}, {tab[k].w_even, tab[k].w_odd});
                if (k > 0) begin
                    chk("s3_pair_spacing", 128'(rd_q[rb + k].c - rd_q[rb + k - 1].c), 128'd3);
                end
            end
        end
        chk("s3_done_rd", 128'(done_rd), 128'd1);
        chk("s3_no_writes_in_drain", 128'(wr_q.size() - wb), 128'd0);

        // 4: replay with a 5-cycle stall on the second pair
        rb = rd_q.size();
        stall = 0; guard = 0;
        snap1 = 16'h0000; snap2 = 16'h0000;
        m_ready = 1'b0;
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        while (rd_q.size() - rb < 4 && guard < 200) begin
            guard++;
            if (m_valid && (rd_q.size() - rb) == 1 && stall < 5) begin
                if (stall == 0) begin
                    snap1 = m_data1;
                    snap2 = m_data2;
                end else begin
                    chk("s4_stall_hold", {m_valid, m_data1, m_data2}, {1'b1, snap1, snap2});
                end
                stall++;
                m_ready = 1'b0;
            end else if (m_valid) begin
                m_ready = 1'b1;
            end else begin
                m_ready = 1'b0;
            end
            cycle();
        end
        m_ready = 1'b0;
        chk("s4_stall_cycles", 128'(stall), 128'd5);
        chk("s4_rd_count", 128'(rd_q.size() - rb), 128'd4);
        for (int k = 0; k < 4; k++) begin
            if (rb + k < rd_q.size()) begin
                chk("s4_rd_vector", {rd_q[rb + k].d1, rd_q[rb + k].d2}, {tab[k].w_even, tab[k].w_odd});
            end
        end

        // 5: new frame, gapped fill with rd_start pokes that must be ignored
        new_frame = 1'b1;
        cycle();
        new_frame = 1'b0;
        chk("s5_flags_cleared", {done_wr, done_rd, s_ready}, {1'b0, 1'b0, 1'b1});
        wb = wr_q.size();
        rb = rd_q.size();
        fill(1, 1'b1);
        check_writes(wb, "s5");
        repeat (6) cycle();
        chk("s5_stays_full", {s_ready, done_wr, done_rd, m_valid, wr}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("s5_no_reads", 128'(rd_q.size() - rb), 128'd0);

        // 6: reset while the third pair is presented
        rb = rd_q.size();
        guard = 0;
        m_ready = 1'b1;
        rd_start = 1'b1;
        cycle();
        rd_start = 1'b0;
        while (rd_q.size() - rb < 2 && guard < 100) begin
            cycle();
            guard++;
        end
        m_ready = 1'b0;
        while (!m_valid && guard < 100) begin
            cycle();
            guard++;
        end
        chk("s6_third_pair", {m_valid, m_data1, m_data2}, {1'b1, 16'h0055, 16'h0066});
        rst = 1'b1;
        cycle();
        chk("s6_reset_drops_valid", {m_valid, done_wr, s_ready}, {1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        chk("s6_pairs_before_reset", 128'(rd_q.size() - rb), 128'd2);
        for (int i = 0; i < NW; i++) begin
            cur_w[i] = 16'hA1 + 16'(i);
        end
        wb = wr_q.size();
        fill(0, 1'b0);
        check_writes(wb, "s6");
        rb = rd_q.size();
        drain(0);
        check_reads(rb, "s6_first");
        rb = rd_q.size();
        drain(0);
        check_reads(rb, "s6_replay");
        chk("s6_done_after_replay", {done_wr, done_rd}, {1'b1, 1'b1});

        // new_frame and rd_start together in S_DONE: the refill wins
        new_frame = 1'b1;
        rd_start  = 1'b1;
        cycle();
        new_frame = 1'b0;
        rd_start  = 1'b0;
        repeat (3) cycle();
        chk("both_pulses_newframe_wins", {s_ready, done_wr, done_rd, m_valid}, {1'b1, 1'b0, 1'b0, 1'b0});

        // Randomized frames: random data, random s_valid gaps, random backpressure
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NW; i++) begin
                cur_w[i] = 16'($urandom);
            end
            wb = wr_q.size();
            fill(2, 1'b0);
            check_writes(wb, "rand");
            rb = rd_q.size();
            drain(1);
            check_reads(rb, "rand");
            new_frame = 1'b1;
            cycle();
            new_frame = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
